// File: rtl/board_status_display.sv
// Board status and seven-segment controller: heartbeat, run/lockup tracking
// and an N-digit display driver with status, hex, blinking hex and lamp-test modes.
module board_status_display #(
    parameter int NUM_DIGITS     = 4,
    parameter int HB_MSB         = 25,
    parameter int RUN_DELAY      = 16,
    parameter int BLINK_BIT      = 23,
    parameter int ACTIVE_LOW_SEG = 1
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    LOCKUP,
    input  logic                    clear_lockup,
    input  logic [1:0]              mode,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic                    running,
    output logic                    heartbeat,
    output logic                    lockup_sticky,
    output logic [7:0]              lockup_count
);

    localparam int DW = (RUN_DELAY > 1) ? $clog2(RUN_DELAY) : 1;
    localparam logic [HB_MSB:0] TICK_ONE = 1;
    localparam logic [7*NUM_DIGITS-1:0] HEX_BLANK = {(7*NUM_DIGITS){ACTIVE_LOW_SEG != 0}};

    localparam logic [6:0] GLYPH_O    = 7'b1011100;
    localparam logic [6:0] GLYPH_R    = 7'b1010000;
    localparam logic [6:0] GLYPH_L    = 7'b0111000;
    localparam logic [6:0] GLYPH_E    = 7'b1111001;
    localparam logic [6:0] GLYPH_DASH = 7'b1000000;

    typedef enum logic [1:0] {IDLE, RUN, LOCKED} state_t;

    state_t                  state;
    logic [DW-1:0]           delay_cnt;
    logic [HB_MSB:0]         tick;
    logic                    lockup_d;
    logic [7*NUM_DIGITS-1:0] lit;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'h3F;
            4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;
            4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;
            4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;
            4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;
            4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;
            default: hex_glyph = 7'h71;
        endcase
    endfunction

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            tick         <= '0;
            heartbeat    <= 1'b0;
            lockup_d     <= 1'b0;
            lockup_count <= '0;
        end else begin
            tick      <= tick + TICK_ONE;
            heartbeat <= tick[HB_MSB] & tick[HB_MSB-2];
            lockup_d  <= LOCKUP;
            if (LOCKUP && !lockup_d && lockup_count != 8'hFF)
                lockup_count <= lockup_count + 8'd1;
        end
    end

    // Status flags are updated alongside the state so they change on the same edge.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state         <= IDLE;
            delay_cnt     <= '0;
            running       <= 1'b0;
            lockup_sticky <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (LOCKUP) begin
                        state         <= LOCKED;
                        running       <= 1'b1;
                        lockup_sticky <= 1'b1;
                    end else if (delay_cnt == DW'(RUN_DELAY - 1)) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else begin
                        delay_cnt <= delay_cnt + DW'(1);
                    end
                end
                RUN: begin
                    if (LOCKUP) begin
                        state         <= LOCKED;
                        lockup_sticky <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (clear_lockup && !LOCKUP) begin
                        state         <= RUN;
                        lockup_sticky <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    running       <= 1'b0;
                    lockup_sticky <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        lit = '0;
        case (mode)
            2'd0: begin
                lit[6:0]   = heartbeat     ? GLYPH_O : 7'b0;
                lit[13:7]  = lockup_sticky ? GLYPH_E : GLYPH_DASH;
                lit[20:14] = running       ? GLYPH_R : 7'b0;
                lit[27:21] = lockup_sticky ? GLYPH_L : 7'b0;
            end
            2'd1, 2'd2: begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    lit[7*i +: 7] = hex_glyph(value[4*i +: 4]);
                if (mode == 2'd2 && lockup_sticky && tick[BLINK_BIT])
                    lit = '0;
            end
            default: lit = '1;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            HEX <= HEX_BLANK;
        else
            HEX <= (ACTIVE_LOW_SEG != 0) ? ~lit : lit;
    end

endmodule

// File: tb/tb_board_status_display.sv
// Randomised self-checking bench for board_status_display against a cycle-level
// behavioural model of the board status rules.
module tb_board_status_display;

    localparam int ND = 6;
    localparam int HB_MSB = 4;
    localparam int RUN_DELAY = 4;
    localparam int BLINK_BIT = 2;

    localparam logic [6:0] G_O = 7'b1011100, G_R = 7'b1010000, G_L = 7'b0111000;
    localparam logic [6:0] G_E = 7'b1111001, G_DASH = 7'b1000000;
    localparam int S_IDLE = 0, S_RUN = 1, S_LOCK = 2;

    logic          HCLK, HRESET, LOCKUP, clear_lockup;
    logic [1:0]    mode;
    logic [4*ND-1:0] value;
    logic [7*ND-1:0] HEX;
    logic          running, heartbeat, lockup_sticky;
    logic [7:0]    lockup_count;
    logic [7*ND+10:0] dut_bus;

    int checks = 0;
    int failures = 0;

    int         m_tick, m_state, m_idle_cycles;
    bit         m_hb, m_run, m_sticky, m_lock_prev;
    logic [7:0] m_count;
    logic [7*ND-1:0] m_hex;

    board_status_display #(
        .NUM_DIGITS(ND), .HB_MSB(HB_MSB), .RUN_DELAY(RUN_DELAY),
        .BLINK_BIT(BLINK_BIT), .ACTIVE_LOW_SEG(1)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .LOCKUP(LOCKUP), .clear_lockup(clear_lockup),
        .mode(mode), .value(value), .HEX(HEX), .running(running),
        .heartbeat(heartbeat), .lockup_sticky(lockup_sticky), .lockup_count(lockup_count)
    );

    assign dut_bus = {HEX, running, heartbeat, lockup_sticky, lockup_count};

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic logic [6:0] glyph_of(input int n);
        case (n)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // What the display should show given the current model state and inputs.
    function automatic logic [7*ND-1:0] model_display();
        logic [6:0] d [ND];
        logic [7*ND-1:0] r;
        for (int i = 0; i < ND; i++) d[i] = 7'b0;
        if (mode == 2'd0) begin
            d[0] = m_hb ? G_O : 7'b0;
            d[1] = m_sticky ? G_E : G_DASH;
            d[2] = m_run ? G_R : 7'b0;
            d[3] = m_sticky ? G_L : 7'b0;
        end else if (mode == 2'd3) begin
            for (int i = 0; i < ND; i++) d[i] = 7'h7F;
        end else begin
            for (int i = 0; i < ND; i++) d[i] = glyph_of(int'((value >> (4*i)) & 24'hF));
            if (mode == 2'd2 && m_sticky && (m_tick % 8) >= 4)
                for (int i = 0; i < ND; i++) d[i] = 7'b0;
        end
        for (int i = 0; i < ND; i++) r[7*i +: 7] = ~d[i];
        return r;
    endfunction

    function automatic logic [7*ND+10:0] model_bus();
        return {m_hex, m_run, m_hb, m_sticky, m_count};
    endfunction

    task automatic model_reset();
        m_tick = 0; m_state = S_IDLE; m_idle_cycles = 0;
        m_hb = 0; m_run = 0; m_sticky = 0; m_lock_prev = 0;
        m_count = 8'd0; m_hex = '1;
    endtask

    task automatic model_edge();
        logic [7*ND-1:0] nhex;
        bit nhb;
        nhex = model_display();
        nhb  = (m_tick >= 16) && ((m_tick % 8) >= 4);
        if (m_state == S_IDLE) begin
            if (LOCKUP) m_state = S_LOCK;
            else if (m_idle_cycles + 1 == RUN_DELAY) m_state = S_RUN;
            else m_idle_cycles++;
        end else if (m_state == S_RUN) begin
            if (LOCKUP) m_state = S_LOCK;
        end else if (clear_lockup && !LOCKUP) begin
            m_state = S_RUN;
        end
        if (LOCKUP && !m_lock_prev && m_count != 8'd255) m_count = m_count + 8'd1;
        m_lock_prev = LOCKUP;
        m_run    = (m_state != S_IDLE);
        m_sticky = (m_state == S_LOCK);
        m_hb     = nhb;
        m_hex    = nhex;
        m_tick   = (m_tick + 1) % 32;
    endtask

    task automatic cycle();
        @(posedge HCLK);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        HRESET = 0; LOCKUP = 0; clear_lockup = 0; mode = 2'd0; value = '0;
        #1 HRESET = 1;
        #1;
        checks++;
        if (dut_bus !== {{(7*ND){1'b1}}, 11'b0}) begin
            failures++;
            $display("[TB] FAIL reset_state: got %h expected %h", dut_bus, {{(7*ND){1'b1}}, 11'b0});
        end
        @(posedge HCLK); #1;
        HRESET = 0;
        model_reset();
        for (int e = 1; e <= 5; e++) begin
            cycle();
            checks++;
            if (running !== (e >= RUN_DELAY)) begin
                failures++;
                $display("[TB] FAIL run_delay edge %0d: got %b expected %b", e, running, e >= RUN_DELAY);
            end
            checks++;
            if (dut_bus !== model_bus()) begin
                failures++;
                $display("[TB] FAIL startup edge %0d: got %h expected %h", e, dut_bus, model_bus());
            end
        end
        checks++;
        if (HEX[20:14] !== 7'b0101111 || HEX[41:28] !== 14'h3FFF) begin
            failures++;
            $display("[TB] FAIL run_glyph: got %b/%h expected 0101111/3fff", HEX[20:14], HEX[41:28]);
        end
    endtask

    task automatic test_heartbeat();
        int highs = 0;
        mode = 2'd0; LOCKUP = 0;
        for (int c = 0; c < 64; c++) begin
            value = 24'($urandom);
            cycle();
            if (heartbeat === 1'b1) highs++;
            checks++;
            if (heartbeat !== m_hb || HEX[6:0] !== m_hex[6:0]) begin
                failures++;
                $display("[TB] FAIL heartbeat cycle %0d: got %b/%b expected %b/%b",
                         c, heartbeat, HEX[6:0], m_hb, m_hex[6:0]);
            end
        end
        checks++;
        if (highs != 16) begin
            failures++;
            $display("[TB] FAIL heartbeat_duty: got %0d expected 16", highs);
        end
    endtask

    task automatic test_lockup();
        mode = 2'd0;
        LOCKUP = 1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            checks++;
            if (lockup_sticky !== 1'b1 || lockup_count !== 8'd1) begin
                failures++;
                $display("[TB] FAIL lockup_enter %0d: got %b/%0d expected 1/1", c, lockup_sticky, lockup_count);
            end
        end
        clear_lockup = 1;
        cycle();
        checks++;
        if (lockup_sticky !== 1'b1 || dut_bus !== model_bus()) begin
            failures++;
            $display("[TB] FAIL clear_ignored: got %h expected %h", dut_bus, model_bus());
        end
        LOCKUP = 0;
        cycle();
        clear_lockup = 0;
        checks++;
        if (lockup_sticky !== 1'b0 || running !== 1'b1 || lockup_count !== 8'd1) begin
            failures++;
            $display("[TB] FAIL clear_accepted: got %b/%b/%0d expected 0/1/1", lockup_sticky, running, lockup_count);
        end
        cycle();
        checks++;
        if (dut_bus !== model_bus()) begin
            failures++;
            $display("[TB] FAIL after_clear: got %h expected %h", dut_bus, model_bus());
        end
    endtask

    task automatic test_saturation();
        for (int p = 0; p < 300; p++) begin
            mode = 2'($urandom_range(3));
            LOCKUP = 1; cycle();
            LOCKUP = 0; cycle();
            checks++;
            if (dut_bus !== model_bus()) begin
                failures++;
                $display("[TB] FAIL saturation pulse %0d: got %h expected %h", p, dut_bus, model_bus());
            end
        end
        checks++;
        if (lockup_count !== 8'd255 || lockup_sticky !== 1'b1) begin
            failures++;
            $display("[TB] FAIL saturate_255: got %0d/%b expected 255/1", lockup_count, lockup_sticky);
        end
    endtask

    task automatic test_blink();
        int blanks = 0;
        logic [7*ND-1:0] shown;
        shown = ~{7'h06, 7'h5B, 7'h77, 7'h7C, 7'h4F, 7'h71};
        value = 24'h12AB3F; mode = 2'd2;
        cycle();
        for (int c = 0; c < 16; c++) begin
            cycle();
            if (HEX === '1) blanks++;
            checks++;
            if (HEX !== m_hex || (HEX !== '1 && HEX !== shown)) begin
                failures++;
                $display("[TB] FAIL blink cycle %0d: got %h expected %h", c, HEX, m_hex);
            end
        end
        checks++;
        if (blanks != 8) begin
            failures++;
            $display("[TB] FAIL blink_duty: got %0d expected 8", blanks);
        end
        mode = 2'd1;
        for (int c = 0; c < 16; c++) begin
            cycle();
            checks++;
            if (HEX !== shown) begin
                failures++;
                $display("[TB] FAIL hex_steady cycle %0d: got %h expected %h", c, HEX, shown);
            end
        end
    endtask

    task automatic test_random();
        HRESET = 1; #1;
        model_reset();
        @(posedge HCLK); #1;
        HRESET = 0;
        for (int c = 0; c < 400; c++) begin
            LOCKUP = ($urandom_range(3) == 0);
            clear_lockup = ($urandom_range(2) == 0);
            mode = 2'($urandom_range(3));
            value = 24'($urandom);
            cycle();
            checks++;
            if (dut_bus !== model_bus()) begin
                failures++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", c, dut_bus, model_bus());
            end
        end
        LOCKUP = 0; clear_lockup = 0;
    endtask

    task automatic test_async_reset();
        mode = 2'd3;
        cycle(); cycle();
        checks++;
        if (HEX !== '0) begin
            failures++;
            $display("[TB] FAIL lamp_test: got %h expected 0", HEX);
        end
        #3 HRESET = 1;
        #1;
        model_reset();
        checks++;
        if (dut_bus !== {{(7*ND){1'b1}}, 11'b0}) begin
            failures++;
            $display("[TB] FAIL async_reset: got %h expected %h", dut_bus, {{(7*ND){1'b1}}, 11'b0});
        end
        @(posedge HCLK); #1;
        HRESET = 0; mode = 2'd0;
        for (int c = 0; c < 24; c++) begin
            cycle();
            checks++;
            if (dut_bus !== model_bus()) begin
                failures++;
                $display("[TB] FAIL restart cycle %0d: got %h expected %h", c, dut_bus, model_bus());
            end
        end
    endtask

    initial begin
        test_reset();
        test_heartbeat();
        test_lockup();
        test_saturation();
        test_blink();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
